mvu_job_dispatcher: RTL and testbench

//  Queues MVU job descriptors and issues them in order to NMVU mvutop lanes. Per job: drives that lane's

---
 rtl/mvu_dispatch_pkg.sv | 28 ++
 rtl/mvu_job_fifo.sv | 57 +++++
 rtl/mvu_job_dispatcher.sv | 174 +++++++++++++++++
 tb/tb_mvu_job_dispatcher.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mvu_dispatch_pkg.sv
// mvu_dispatch_pkg: MVU job descriptor layout and dispatcher FSM states.
`default_nettype none

package mvu_dispatch_pkg;

  localparam int BCNTDWN = 29;
  localparam int BPREC   = 6;
  localparam int BBWADDR = 9;
  localparam int BBDADDR = 15;
  // Lane index field; wide enough to carry out-of-range indices so they can be flagged.
  localparam int BMVU    = 4;

  typedef struct packed {
    logic [BMVU-1:0]    mvu;
    logic [BCNTDWN-1:0] countdown;
    logic [BPREC-1:0]   wprec;
    logic [BPREC-1:0]   iprec;
    logic [BPREC-1:0]   oprec;
    logic [BBWADDR-1:0] wbase;
    logic [BBDADDR-1:0] ibase;
    logic [BBDADDR-1:0] obase;
  } mvu_job_t;

  typedef enum logic [0:0] {IDLE, ISSUE} disp_state_e;

endpackage

`default_nettype wire

// File: rtl/mvu_job_fifo.sv
// mvu_job_fifo: synchronous job descriptor FIFO with flush; flush overrides push and pop.
`default_nettype none

module mvu_job_fifo
  import mvu_dispatch_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  mvu_job_t                 wdata,
  input  logic                     pop,
  output mvu_job_t                 rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  mvu_job_t        mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

`default_nettype wire

// File: rtl/mvu_job_dispatcher.sv
// mvu_job_dispatcher: in-order MVU job issue to NMVU lanes with busy/err tracking.
// Optional per-lane timeout enabled by defining MVU_DISPATCH_TIMEOUT_EN.
`default_nettype none

module mvu_job_dispatcher
  import mvu_dispatch_pkg::*;
#(
  parameter int NMVU     = 1,
  parameter int DEPTH    = 8,
  parameter int BCNTW    = 16,
  parameter int TOMARGIN = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      job_valid,
  output logic                      job_ready,
  input  mvu_job_t                  job,
  input  logic                      flush,
  input  logic [NMVU-1:0]           done,
  output logic [NMVU-1:0]           start,
  output logic [NMVU*BCNTDWN-1:0]   countdown,
  output logic [NMVU*BPREC-1:0]     wprecision,
  output logic [NMVU*BPREC-1:0]     iprecision,
  output logic [NMVU*BPREC-1:0]     oprecision,
  output logic [NMVU*BBWADDR-1:0]   wbaseaddr,
  output logic [NMVU*BBDADDR-1:0]   ibaseaddr,
  output logic [NMVU*BBDADDR-1:0]   obaseaddr,
  output logic [NMVU-1:0]           busy,
  output logic [$clog2(DEPTH):0]    q_count,
  output logic [BCNTW-1:0]          jobs_done,
  output logic [NMVU-1:0]           err
);

  mvu_job_t    head;
  logic        q_full;
  logic        q_empty;
  logic        pop;
  logic        issue;
  logic        head_bad;
  logic        head_busy;
  logic [NMVU-1:0] done_ok;
  disp_state_e state;
  disp_state_e state_nxt;

  logic [BCNTDWN-1:0] cd_q [NMVU];
  logic [BPREC-1:0]   wp_q [NMVU];
  logic [BPREC-1:0]   ip_q [NMVU];
  logic [BPREC-1:0]   op_q [NMVU];
  logic [BBWADDR-1:0] wb_q [NMVU];
  logic [BBDADDR-1:0] ib_q [NMVU];
  logic [BBDADDR-1:0] ob_q [NMVU];

  mvu_job_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (job_valid),
    .wdata (job),
    .pop   (pop),
    .rdata (head),
    .full  (q_full),
    .empty (q_empty),
    .count (q_count)
  );

  assign job_ready = !q_full;
  assign head_bad  = (int'(head.mvu) >= NMVU);
  // A done coinciding with its own start pulse cannot belong to that job.
  assign done_ok   = done & busy & ~start;

  always_comb begin
    head_busy = 1'b0;
    for (int i = 0; i < NMVU; i++) begin
      if (head.mvu == BMVU'(i)) head_busy = busy[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    issue     = 1'b0;
    case (state)
      IDLE: begin
        if (!q_empty && !flush && !head_busy) state_nxt = ISSUE;
      end
      ISSUE: begin
        state_nxt = IDLE;
        if (!flush) begin
          pop   = 1'b1;
          issue = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef MVU_DISPATCH_TIMEOUT_EN
  localparam int TOW = BCNTDWN + 1;
  logic [TOW-1:0] to_cnt [NMVU];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      start     <= '0;
      busy      <= '0;
      err       <= '0;
      jobs_done <= '0;
      for (int i = 0; i < NMVU; i++) begin
        cd_q[i] <= '0;
        wp_q[i] <= '0;
        ip_q[i] <= '0;
        op_q[i] <= '0;
        wb_q[i] <= '0;
        ib_q[i] <= '0;
        ob_q[i] <= '0;
`ifdef MVU_DISPATCH_TIMEOUT_EN
        to_cnt[i] <= '0;
`endif
      end
    end else begin
      start     <= '0;
      jobs_done <= jobs_done + BCNTW'($countones(done_ok));
      if (issue && head_bad) err[0] <= 1'b1;
      for (int i = 0; i < NMVU; i++) begin
        if (done[i] && !done_ok[i]) err[i] <= 1'b1;
        if (issue && head.mvu == BMVU'(i)) begin
          cd_q[i]  <= head.countdown;
          wp_q[i]  <= head.wprec;
          ip_q[i]  <= head.iprec;
          op_q[i]  <= head.oprec;
          wb_q[i]  <= head.wbase;
          ib_q[i]  <= head.ibase;
          ob_q[i]  <= head.obase;
          start[i] <= 1'b1;
          busy[i]  <= 1'b1;
`ifdef MVU_DISPATCH_TIMEOUT_EN
          to_cnt[i] <= TOW'(head.countdown) + TOW'(TOMARGIN);
`endif
        end else if (done_ok[i]) begin
          busy[i] <= 1'b0;
        end
`ifdef MVU_DISPATCH_TIMEOUT_EN
        else if (busy[i]) begin
          if (to_cnt[i] <= TOW'(1)) begin
            busy[i]   <= 1'b0;
            err[i]    <= 1'b1;
            to_cnt[i] <= '0;
          end else begin
            to_cnt[i] <= to_cnt[i] - 1'b1;
          end
        end
`endif
      end
    end
  end

  for (genvar g = 0; g < NMVU; g++) begin : g_lane
    assign countdown [g*BCNTDWN +: BCNTDWN] = cd_q[g];
    assign wprecision[g*BPREC   +: BPREC]   = wp_q[g];
    assign iprecision[g*BPREC   +: BPREC]   = ip_q[g];
    assign oprecision[g*BPREC   +: BPREC]   = op_q[g];
    assign wbaseaddr [g*BBWADDR +: BBWADDR] = wb_q[g];
    assign ibaseaddr [g*BBDADDR +: BBDADDR] = ib_q[g];
    assign obaseaddr [g*BBDADDR +: BBDADDR] = ob_q[g];
  end

endmodule

`default_nettype wire

// File: tb/tb_mvu_job_dispatcher.sv
// Directed testbench for mvu_job_dispatcher with two lanes and a 4-entry queue.
`default_nettype none

module tb_mvu_job_dispatcher;
  import mvu_dispatch_pkg::*;

  localparam int NMVU     = 2;
  localparam int DEPTH    = 4;
  localparam int BCNTW    = 16;
  localparam int TOMARGIN = 8;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic                     job_valid = 1'b0;
  logic                     job_ready;
  mvu_job_t                 job = '0;
  logic                     flush = 1'b0;
  logic [NMVU-1:0]          done = '0;
  logic [NMVU-1:0]          start;
  logic [NMVU*BCNTDWN-1:0]  countdown;
  logic [NMVU*BPREC-1:0]    wprecision;
  logic [NMVU*BPREC-1:0]    iprecision;
  logic [NMVU*BPREC-1:0]    oprecision;
  logic [NMVU*BBWADDR-1:0]  wbaseaddr;
  logic [NMVU*BBDADDR-1:0]  ibaseaddr;
  logic [NMVU*BBDADDR-1:0]  obaseaddr;
  logic [NMVU-1:0]          busy;
  logic [$clog2(DEPTH):0]   q_count;
  logic [BCNTW-1:0]         jobs_done;
  logic [NMVU-1:0]          err;

  int errors = 0;
  int checks = 0;

  mvu_job_dispatcher #(
    .NMVU(NMVU), .DEPTH(DEPTH), .BCNTW(BCNTW), .TOMARGIN(TOMARGIN)
  ) dut (
    .clk(clk), .rst(rst), .job_valid(job_valid), .job_ready(job_ready), .job(job),
    .flush(flush), .done(done), .start(start), .countdown(countdown),
    .wprecision(wprecision), .iprecision(iprecision), .oprecision(oprecision),
    .wbaseaddr(wbaseaddr), .ibaseaddr(ibaseaddr), .obaseaddr(obaseaddr),
    .busy(busy), .q_count(q_count), .jobs_done(jobs_done), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic mvu_job_t mk_job(input logic [BMVU-1:0] m, input logic [BCNTDWN-1:0] cd);
    mvu_job_t j;
    j.mvu       = m;
    j.countdown = cd;
    j.wprec     = 6'd2;
    j.iprec     = 6'd2;
    j.oprec     = 6'd2;
    j.wbase     = 9'd3;
    j.ibase     = 15'd100;
    j.obase     = 15'd200;
    return j;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_job(input logic [BMVU-1:0] m, input logic [BCNTDWN-1:0] cd);
    job       = mk_job(m, cd);
    job_valid = 1'b1;
    tick();
    job_valid = 1'b0;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    push_job(4'd0, 29'd5);
    push_job(4'd0, 29'd6);
    tick();
    tick();
    checks++; if (busy !== 2'b01) begin errors++; $display("FAIL reset_pre_busy: got %b want 01", busy); end
    checks++; if (q_count !== 3'd1) begin errors++; $display("FAIL reset_pre_qcount: got %0d want 1", q_count); end
    do_reset();
    checks++; if (start !== 2'b00) begin errors++; $display("FAIL reset_start: got %b want 00", start); end
    checks++; if (busy !== 2'b00) begin errors++; $display("FAIL reset_busy: got %b want 00", busy); end
    checks++; if (q_count !== 3'd0) begin errors++; $display("FAIL reset_qcount: got %0d want 0", q_count); end
    checks++; if (job_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", job_ready); end
    checks++; if (jobs_done !== 16'd0) begin errors++; $display("FAIL reset_jobs_done: got %0d want 0", jobs_done); end
    checks++; if (err !== 2'b00) begin errors++; $display("FAIL reset_err: got %b want 00", err); end
  endtask

  task automatic test_single;
    push_job(4'd0, 29'd16);
    checks++; if (start !== 2'b00) begin errors++; $display("FAIL single_start_t: got %b want 00", start); end
    tick();
    checks++; if (start !== 2'b00) begin errors++; $display("FAIL single_start_t1: got %b want 00", start); end
    tick();
    checks++; if (start !== 2'b01) begin errors++; $display("FAIL single_start_t2: got %b want 01", start); end
    checks++; if (countdown[28:0] !== 29'd16) begin errors++; $display("FAIL single_countdown: got %0d want 16", countdown[28:0]); end
    checks++; if ({wprecision[5:0], iprecision[5:0], oprecision[5:0]} !== {6'd2, 6'd2, 6'd2}) begin
      errors++; $display("FAIL single_prec: got %0d/%0d/%0d want 2/2/2", wprecision[5:0], iprecision[5:0], oprecision[5:0]);
    end
    checks++; if (ibaseaddr[14:0] !== 15'd100) begin errors++; $display("FAIL single_ibase: got %0d want 100", ibaseaddr[14:0]); end
    checks++; if (busy !== 2'b01) begin errors++; $display("FAIL single_busy_start: got %b want 01", busy); end
    repeat (4) tick();
    checks++; if (start !== 2'b00) begin errors++; $display("FAIL single_start_pulse: got %b want 00", start); end
    checks++; if (busy !== 2'b01) begin errors++; $display("FAIL single_busy_hold: got %b want 01", busy); end
    done = 2'b01;
    tick();
    done = 2'b00;
    checks++; if (busy !== 2'b00) begin errors++; $display("FAIL single_busy_clear: got %b want 00", busy); end
    checks++; if (jobs_done !== 16'd1) begin errors++; $display("FAIL single_jobs_done: got %0d want 1", jobs_done); end
    checks++; if (err !== 2'b00) begin errors++; $display("FAIL single_err: got %b want 00", err); end
  endtask

  task automatic test_in_order;
    int t0 = -1;
    int t1 = -1;
    logic saw1 = 1'b0;
    push_job(4'd0, 29'd10);
    push_job(4'd0, 29'd20);
    push_job(4'd1, 29'd30);
    checks++; if (start !== 2'b01) begin errors++; $display("FAIL order_first_start: got %b want 01", start); end
    checks++; if (countdown[28:0] !== 29'd10) begin errors++; $display("FAIL order_first_cd: got %0d want 10", countdown[28:0]); end
    repeat (6) begin
      tick();
      if (start[1]) saw1 = 1'b1;
    end
    checks++; if (saw1 !== 1'b0) begin errors++; $display("FAIL order_hol_block: lane1 started=%b want 0", saw1); end
    checks++; if (q_count !== 3'd2) begin errors++; $display("FAIL order_qcount: got %0d want 2", q_count); end
    done = 2'b01;
    tick();
    done = 2'b00;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (start[0]) begin
        t0 = k;
        checks++; if (countdown[28:0] !== 29'd20) begin errors++; $display("FAIL order_cd0: got %0d want 20", countdown[28:0]); end
      end
      if (start[1]) begin
        t1 = k;
        checks++; if (countdown[57:29] !== 29'd30) begin errors++; $display("FAIL order_cd1: got %0d want 30", countdown[57:29]); end
      end
    end
    checks++; if (t0 !== 1) begin errors++; $display("FAIL order_t0: got %0d want 1", t0); end
    checks++; if (t1 !== 3) begin errors++; $display("FAIL order_t1: got %0d want 3", t1); end
    done = 2'b11;
    tick();
    done = 2'b00;
    checks++; if (jobs_done !== 16'd4) begin errors++; $display("FAIL order_jobs_done: got %0d want 4", jobs_done); end
    checks++; if (busy !== 2'b00) begin errors++; $display("FAIL order_busy: got %b want 00", busy); end
  endtask

  task automatic test_full_flush;
    logic saw = 1'b0;
    push_job(4'd0, 29'd100);
    tick();
    tick();
    checks++; if (busy !== 2'b01) begin errors++; $display("FAIL full_busy: got %b want 01", busy); end
    for (int i = 0; i < DEPTH + 1; i++) begin
      if (i == DEPTH) begin
        checks++; if (job_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b want 0", job_ready); end
      end
      job       = mk_job(4'd0, 29'(i + 1));
      job_valid = 1'b1;
      tick();
    end
    job_valid = 1'b0;
    checks++; if (q_count !== 3'd4) begin errors++; $display("FAIL full_qcount: got %0d want 4", q_count); end
    flush     = 1'b1;
    job_valid = 1'b1;
    tick();
    flush     = 1'b0;
    job_valid = 1'b0;
    checks++; if (q_count !== 3'd0) begin errors++; $display("FAIL flush_qcount: got %0d want 0", q_count); end
    checks++; if (job_ready !== 1'b1) begin errors++; $display("FAIL flush_ready: got %b want 1", job_ready); end
    checks++; if (busy !== 2'b01) begin errors++; $display("FAIL flush_inflight: got %b want 01", busy); end
    checks++; if (countdown[28:0] !== 29'd100) begin errors++; $display("FAIL flush_cfg_hold: got %0d want 100", countdown[28:0]); end
    done = 2'b01;
    tick();
    done = 2'b00;
    repeat (4) begin
      tick();
      if (start !== 2'b00) saw = 1'b1;
    end
    checks++; if (saw !== 1'b0) begin errors++; $display("FAIL flush_no_start: started=%b want 0", saw); end
    checks++; if (jobs_done !== 16'd5) begin errors++; $display("FAIL flush_jobs_done: got %0d want 5", jobs_done); end
  endtask

  task automatic test_errors;
    logic saw = 1'b0;
    done = 2'b10;
    tick();
    done = 2'b00;
    checks++; if (err !== 2'b10) begin errors++; $display("FAIL spurious_err: got %b want 10", err); end
    checks++; if (jobs_done !== 16'd5) begin errors++; $display("FAIL spurious_jobs_done: got %0d want 5", jobs_done); end
    push_job(4'd5, 29'd7);
    repeat (4) begin
      if (start !== 2'b00) saw = 1'b1;
      tick();
    end
    checks++; if (saw !== 1'b0) begin errors++; $display("FAIL badidx_start: started=%b want 0", saw); end
    checks++; if (q_count !== 3'd0) begin errors++; $display("FAIL badidx_qcount: got %0d want 0", q_count); end
    checks++; if (err !== 2'b11) begin errors++; $display("FAIL badidx_err: got %b want 11", err); end
    checks++; if (busy !== 2'b00) begin errors++; $display("FAIL badidx_busy: got %b want 00", busy); end
  endtask

`ifdef MVU_DISPATCH_TIMEOUT_EN
  task automatic test_timeout;
    do_reset();
    push_job(4'd1, 29'd4);
    tick();
    tick();
    checks++; if (start !== 2'b10) begin errors++; $display("FAIL to_start: got %b want 10", start); end
    repeat (11) tick();
    checks++; if (busy !== 2'b10) begin errors++; $display("FAIL to_busy_11: got %b want 10", busy); end
    checks++; if (err !== 2'b00) begin errors++; $display("FAIL to_err_early: got %b want 00", err); end
    tick();
    checks++; if (busy !== 2'b00) begin errors++; $display("FAIL to_busy_12: got %b want 00", busy); end
    checks++; if (err !== 2'b10) begin errors++; $display("FAIL to_err: got %b want 10", err); end
    checks++; if (jobs_done !== 16'd0) begin errors++; $display("FAIL to_jobs_done: got %0d want 0", jobs_done); end
  endtask
`else
  task automatic test_no_timeout;
    do_reset();
    push_job(4'd1, 29'd4);
    tick();
    tick();
    checks++; if (start !== 2'b10) begin errors++; $display("FAIL hold_start: got %b want 10", start); end
    repeat (40) tick();
    checks++; if (busy !== 2'b10) begin errors++; $display("FAIL hold_busy: got %b want 10", busy); end
    checks++; if (err !== 2'b00) begin errors++; $display("FAIL hold_err: got %b want 00", err); end
    done = 2'b10;
    tick();
    done = 2'b00;
    checks++; if (busy !== 2'b00) begin errors++; $display("FAIL hold_busy_clear: got %b want 00", busy); end
    checks++; if (jobs_done !== 16'd1) begin errors++; $display("FAIL hold_jobs_done: got %0d want 1", jobs_done); end
  endtask
`endif

  initial begin
    do_reset();
    test_reset();
    test_single();
    test_in_order();
    test_full_flush();
    test_errors();
`ifdef MVU_DISPATCH_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
